// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data-side memory bus: FSM encoding,
// address window layout and requester ids.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } bus_state_e;

    typedef enum logic [1:0] {
        TGT_PLIC  = 2'b00,
        TGT_CLINT = 2'b01,
        TGT_IO    = 2'b10,
        TGT_SRAM  = 2'b11
    } bus_target_e;

    localparam int SRAM_TOP_DEF  = 10;
    localparam int PERIPH_SEL_HI = 7;
    localparam int PERIPH_SEL_LO = 6;

    localparam logic [1:0] PERIPH_PLIC  = 2'b00;
    localparam logic [1:0] PERIPH_CLINT = 2'b01;
    localparam logic [1:0] PERIPH_IO    = 2'b10;
    localparam logic [1:0] PERIPH_RESVD = 2'b11;

    localparam logic PORT_LSU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address legality and target decode for the memory bus.
// Shared between the data-side arbiter and the fetch-side bus.
module mem_addr_decode
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int SRAM_TOP = SRAM_TOP_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              legal,
    output logic [1:0]        target
);

    logic              aligned_s;
    logic              in_range_s;
    logic [ADDR_W-1:0] upper_s;

    // Alignment, window range and peripheral-select decode
    always_comb begin
        upper_s    = addr >> (SRAM_TOP + 1);
        aligned_s  = (addr[1:0] == 2'b00);
        in_range_s = (upper_s == {ADDR_W{1'b0}});
        if (addr[SRAM_TOP]) begin
            target = addr[PERIPH_SEL_HI:PERIPH_SEL_LO];
            legal  = aligned_s && in_range_s &&
                     (addr[PERIPH_SEL_HI:PERIPH_SEL_LO] != PERIPH_RESVD);
        end else begin
            target = TGT_SRAM;
            legal  = aligned_s && in_range_s;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the shared data-memory/peripheral bus.
// Every access runs a fixed IDLE -> ISSUE -> CAPTURE -> RESP sequence.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SRAM_TOP = SRAM_TOP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic              rerr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic              rerr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_load,
    output logic              mem_store,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    bus_state_e        state_r;
    bus_state_e        state_nxt_s;
    logic              last_grant_r;
    logic              winner_r;
    logic              we_r;
    logic              legal_r;
    logic              take_s;
    logic              pick_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              dec_legal_s;
    logic [1:0]        dec_target_s;
    logic              legal_s;
    logic              gnt0_nxt_s;
    logic              gnt1_nxt_s;
    logic              load_nxt_s;
    logic              store_nxt_s;
    logic              rvalid0_nxt_s;
    logic              rvalid1_nxt_s;
    logic [DATA_W-1:0] resp_data_s;

    // Arbitration and next-state; requests are only looked at in IDLE
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        pick_s      = PORT_LSU;
        case (state_r)
            ST_IDLE: begin
                if (req0 && req1) begin
                    take_s = 1'b1;
                    pick_s = ~last_grant_r;
                end else if (req0) begin
                    take_s = 1'b1;
                    pick_s = PORT_LSU;
                end else if (req1) begin
                    take_s = 1'b1;
                    pick_s = PORT_DMA;
                end else begin
                    take_s = 1'b0;
                    pick_s = PORT_LSU;
                end
                if (take_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE:   state_nxt_s = ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = ST_RESP;
            ST_RESP:    state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Request field mux for the arbitration winner
    always_comb begin
        if (pick_s == PORT_DMA) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    mem_addr_decode #(
        .ADDR_W   (ADDR_W),
        .SRAM_TOP (SRAM_TOP)
    ) u_decode (
        .addr   (sel_addr_s),
        .legal  (dec_legal_s),
        .target (dec_target_s)
    );

    // The target must agree with the window bit; any disagreement is treated as illegal
    assign legal_s = dec_legal_s &&
                     ((dec_target_s == TGT_SRAM) == ~sel_addr_s[SRAM_TOP]);

    // Next values of the registered pulse outputs and the response data
    always_comb begin
        gnt0_nxt_s    = take_s && (pick_s == PORT_LSU);
        gnt1_nxt_s    = take_s && (pick_s == PORT_DMA);
        load_nxt_s    = take_s && legal_s && !sel_we_s;
        store_nxt_s   = take_s && legal_s && sel_we_s;
        rvalid0_nxt_s = (state_r == ST_CAPTURE) && (winner_r == PORT_LSU);
        rvalid1_nxt_s = (state_r == ST_CAPTURE) && (winner_r == PORT_DMA);
        if (legal_r && !we_r) begin
            resp_data_s = mem_rdata;
        end else begin
            resp_data_s = {DATA_W{1'b0}};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latched access fields; mem_addr/mem_wdata only move on IDLE->ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= PORT_DMA;
            winner_r     <= PORT_LSU;
            we_r         <= 1'b0;
            legal_r      <= 1'b0;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= {DATA_W{1'b0}};
        end else if (take_s) begin
            last_grant_r <= pick_s;
            winner_r     <= pick_s;
            we_r         <= sel_we_s;
            legal_r      <= legal_s;
            mem_addr     <= sel_addr_s;
            mem_wdata    <= sel_wdata_s;
        end
    end

    // Registered grant, strobe and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            mem_load  <= 1'b0;
            mem_store <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rerr0     <= 1'b0;
            rerr1     <= 1'b0;
            rdata0    <= {DATA_W{1'b0}};
            rdata1    <= {DATA_W{1'b0}};
        end else begin
            gnt0      <= gnt0_nxt_s;
            gnt1      <= gnt1_nxt_s;
            mem_load  <= load_nxt_s;
            mem_store <= store_nxt_s;
            rvalid0   <= rvalid0_nxt_s;
            rvalid1   <= rvalid1_nxt_s;
            rerr0     <= rvalid0_nxt_s && !legal_r;
            rerr1     <= rvalid1_nxt_s && !legal_r;
            if (rvalid0_nxt_s) begin
                rdata0 <= resp_data_s;
            end
            if (rvalid1_nxt_s) begin
                rdata1 <= resp_data_s;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_v;
    logic [1:0]  we_v;
    logic [31:0] addr_v [2];
    logic [31:0] wdata_v [2];
    logic        gnt0, rvalid0, rerr0, gnt1, rvalid1, rerr1;
    logic [31:0] rdata0, rdata1;
    logic        mem_load, mem_store;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req_v[0]), .we0(we_v[0]), .addr0(addr_v[0]), .wdata0(wdata_v[0]),
        .gnt0(gnt0), .rvalid0(rvalid0), .rerr0(rerr0), .rdata0(rdata0),
        .req1(req_v[1]), .we1(we_v[1]), .addr1(addr_v[1]), .wdata1(wdata_v[1]),
        .gnt1(gnt1), .rvalid1(rvalid1), .rerr1(rerr1), .rdata1(rdata1),
        .mem_load(mem_load), .mem_store(mem_store), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       rq0[$];
    resp_t       rq1[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          idle_from = 0;
    int          gcnt [2] = '{0, 0};
    int          seen [2] = '{0, 0};
    int          tmo_req = 0;
    int          tmo_seen = 0;
    bit          started = 1'b0;
    bit          rst_last = 1'b0;
    bit          last_g = 1'b1;
    bit          g_valid = 1'b0;
    int          g_cyc = 0;
    bit          g_port, g_we, g_legal, w;
    logic [31:0] g_addr, g_wdata;
    logic [31:0] held_rdata [2] = '{32'd0, 32'd0};
    logic [31:0] held_addr = 32'd0;
    logic [31:0] held_wdata = 32'd0;
    logic [7:0]  exp_ctl, act_ctl;
    bit          bus_pend = 1'b0;
    logic [31:0] bus_addr = 32'd0;
    resp_t       r;

    // Legality from the address map: word aligned, below 2 KiB, and not the
    // reserved quarter of the peripheral window.
    function automatic bit ref_legal(input logic [31:0] a);
        if (a % 32'd4 != 32'd0) return 1'b0;
        if (a >= 32'd2048) return 1'b0;
        if (a >= 32'd1024 && ((a / 32'd64) % 32'd4) == 32'd3) return 1'b0;
        return 1'b1;
    endfunction

    // Contents the bus model returns for a read
    function automatic logic [31:0] bus_data(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r4;
        r4 = 32'($urandom_range(0, 255)) * 32'd4;
        case ($urandom_range(0, 4))
            0: return r4;
            1: return 32'h0000_0400 + r4;
            2: return r4 + 32'($urandom_range(1, 3));
            3: return 32'($urandom());
            default: return 32'h0000_0800 | r4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Bus model: read data is valid for the whole cycle after mem_load, junk otherwise
    always @(posedge clk) begin
        #1;
        if (bus_pend) mem_rdata = bus_data(bus_addr);
        else          mem_rdata = $urandom();
    end

    // Monitor/scoreboard and arbitration reference model, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        act_ctl = {gnt1, gnt0, mem_load, mem_store, rvalid1, rvalid0, rerr1, rerr0};
        if (rst_last) begin
            chk("reset_ctl", 64'(act_ctl), 64'd0);
            chk("reset_rdata", {rdata1, rdata0}, 64'd0);
            chk("reset_bus", {mem_addr, mem_wdata}, 64'd0);
            rq0.delete();
            rq1.delete();
            g_valid = 1'b0;
            last_g = 1'b1;
            idle_from = cyc;
            held_rdata[0] = 32'd0;
            held_rdata[1] = 32'd0;
            held_addr = 32'd0;
            held_wdata = 32'd0;
            started = 1'b1;
        end else if (started) begin
            exp_ctl = 8'd0;
            if (g_valid && g_cyc == cyc) begin
                exp_ctl[g_port ? 7 : 6] = 1'b1;
                exp_ctl[5] = g_legal && !g_we;
                exp_ctl[4] = g_legal && g_we;
                held_addr = g_addr;
                held_wdata = g_wdata;
                r.err = !g_legal;
                r.data = (g_legal && !g_we) ? bus_data(g_addr) : 32'd0;
                r.due = cyc + 2;
                if (g_port) rq1.push_back(r);
                else        rq0.push_back(r);
                g_valid = 1'b0;
            end
            if (rq0.size() > 0 && rq0[0].due == cyc) begin
                r = rq0.pop_front();
                exp_ctl[2] = 1'b1;
                exp_ctl[0] = r.err;
                held_rdata[0] = r.data;
            end
            if (rq1.size() > 0 && rq1[0].due == cyc) begin
                r = rq1.pop_front();
                exp_ctl[3] = 1'b1;
                exp_ctl[1] = r.err;
                held_rdata[1] = r.data;
            end
            chk("ctl{g1,g0,ld,st,v1,v0,e1,e0}", 64'(act_ctl), 64'(exp_ctl));
            chk("rdata{1,0}", {rdata1, rdata0}, {held_rdata[1], held_rdata[0]});
            chk("bus{addr,wdata}", {mem_addr, mem_wdata}, {held_addr, held_wdata});
        end
        if (tmo_req != tmo_seen) begin
            chk("grant_timeout", 64'(tmo_req), 64'(tmo_seen));
            tmo_seen = tmo_req;
        end
        bus_pend = (mem_load === 1'b1);
        bus_addr = mem_addr;
        if (started && !rst && cyc >= idle_from && req_v != 2'b00) begin
            w = (req_v == 2'b11) ? ~last_g : req_v[1];
            g_valid = 1'b1;
            g_cyc = cyc + 1;
            g_port = w;
            g_we = we_v[w];
            g_addr = addr_v[w];
            g_wdata = wdata_v[w];
            g_legal = ref_legal(addr_v[w]);
            last_g = w;
            idle_from = cyc + 4;
            gcnt[w]++;
        end
        rst_last = rst;
    end

    task automatic wait_grant(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (gcnt[k] != seen[k]) begin
                seen[k] = gcnt[k];
                ok = 1'b1;
                break;
            end
        end
        req_v[k] = 1'b0;
        if (!ok) tmo_req++;
    endtask

    task automatic do_access(input int k, input bit we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        we_v[k] = we; addr_v[k] = a; wdata_v[k] = d; req_v[k] = 1'b1;
        wait_grant(k);
        repeat (4) @(posedge clk);
    endtask

    // Hold both requests until n grants in total have been issued
    task automatic hold_both(input int n);
        int base;
        base = gcnt[0] + gcnt[1];
        req_v = 2'b11;
        for (int i = 0; i < 8 * n && (gcnt[0] + gcnt[1] - base) < n; i++) begin
            @(posedge clk); #1;
        end
        if ((gcnt[0] + gcnt[1] - base) < n) tmo_req++;
        req_v = 2'b00;
        seen[0] = gcnt[0];
        seen[1] = gcnt[1];
        repeat (4) @(posedge clk);
    endtask

    int gap [2] = '{0, 0};

    initial begin
        rst = 1'b1; req_v = 2'b00; we_v = 2'b00;
        addr_v[0] = 32'd0; addr_v[1] = 32'd0; wdata_v[0] = 32'd0; wdata_v[1] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        addr_v[0] = 32'h0000_0100; addr_v[1] = 32'h0000_0104;
        hold_both(4);

        do_access(0, 1'b0, 32'h0000_0010, 32'h1234_5678);
        do_access(1, 1'b1, 32'h0000_0480, 32'h0000_00FF);
        do_access(0, 1'b0, 32'h0000_0402, 32'd0);
        do_access(0, 1'b0, 32'h0000_04C0, 32'd0);
        do_access(0, 1'b1, 32'h0000_0800, 32'hCAFE_0001);

        // Reset in the CAPTURE cycle of a read, then a tie straight after release
        @(posedge clk); #1;
        we_v[0] = 1'b0; addr_v[0] = 32'h0000_0020; req_v[0] = 1'b1;
        wait_grant(0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        we_v = 2'b01; addr_v[0] = 32'h0000_0044; addr_v[1] = 32'h0000_0408;
        wdata_v[0] = 32'hA5A5_0000;
        hold_both(2);

        // One-cycle req1 pulse while port 0 is in CAPTURE
        @(posedge clk); #1;
        we_v[0] = 1'b0; addr_v[0] = 32'h0000_0030; req_v[0] = 1'b1;
        wait_grant(0);
        @(posedge clk); #1;
        addr_v[1] = 32'h0000_0034; req_v[1] = 1'b1;
        @(posedge clk); #1;
        req_v[1] = 1'b0;
        repeat (10) @(posedge clk);

        // Random traffic with occasional withdrawn requests
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (gcnt[k] != seen[k]) begin
                    seen[k] = gcnt[k];
                    req_v[k] = 1'b0;
                    gap[k] = $urandom_range(0, 3);
                end else if (req_v[k]) begin
                    if ($urandom_range(0, 15) == 0) begin
                        req_v[k] = 1'b0;
                        gap[k] = 1;
                    end
                end else if (gap[k] > 0) begin
                    gap[k]--;
                end else begin
                    we_v[k] = 1'($urandom_range(0, 1));
                    addr_v[k] = rand_addr();
                    wdata_v[k] = $urandom();
                    req_v[k] = 1'b1;
                end
            end
        end
        req_v = 2'b00;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
